tdc_sequencer: RTL and testbench
================================

TDC_SEQUENCER -- requirements
Module: tdc_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles spent in WAIT per sample before abort (legal 2..255).
REQ-002 SHALL have port ref_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a measurement burst; sampled only in IDLE.
REQ-005 SHALL have port avg_log2  input  2  burst length N = 2^avg_log2 (1, 2, 4 or 8 samples); latched on accepted start.
REQ-006 SHALL have port tdc_clr  output  1  one-cycle clear pulse to TDC counters.
REQ-007 SHALL have port tdc_en  output  1  TDC measurement enable.
REQ-008 SHALL have port tdc_done  input  1  single-cycle strobe: phase_error valid.
REQ-009 SHALL have port phase_error  input  10  TDC result {coarse[7:0], fine[1:0]}, unsigned.
REQ-010 SHALL have port avg_out  output  10  averaged phase error.
REQ-011 SHALL have port avg_valid  output  1  avg_out valid; held until accepted.
REQ-012 SHALL have port avg_ready  input  1  consumer accepts avg_out.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse on burst abort.

Function
REQ-015 SHALL implement FSM states IDLE, CLR, WAIT, OUT.
REQ-016 IDLE: start=1 -> CLR next edge; latch avg_log2; clear 13-bit accumulator and 3-bit sample counter.
REQ-017 CLR: tdc_clr=1, tdc_en=0, exactly one cycle; -> WAIT unconditionally; WAIT timer cleared to 0.
REQ-018 WAIT: tdc_en=1, tdc_clr=0; timer increments each cycle without tdc_done.
REQ-019 WAIT with tdc_done=1: acc <= acc + phase_error (13-bit, no overflow possible for N<=8); if sample counter == N-1 -> OUT, else counter+1 and -> CLR.
REQ-020 On WAIT -> OUT transition: avg_out <= (acc + phase_error) >> latched avg_log2, truncating (floor).
REQ-021 WAIT with tdc_done=0 and timer == TIMEOUT-1: -> IDLE; timeout_err=1 for the following cycle only; accumulator discarded; avg_out unchanged.
REQ-022 tdc_done and timeout in same cycle: tdc_done wins, no timeout_err.
REQ-023 OUT: avg_valid=1, tdc_en=0; avg_out stable; on avg_valid & avg_ready -> IDLE next edge.
REQ-024 avg_ready while avg_valid=0 SHALL have no effect; tdc_done outside WAIT SHALL be ignored.
REQ-025 start while busy=1 SHALL be ignored (not queued); start in the handshake cycle of OUT ignored.
REQ-026 avg_log2 changes after start SHALL not affect the burst in progress.
REQ-027 Latency: start high at edge k -> tdc_clr high cycle k+1 -> tdc_en high from cycle k+2.
REQ-028 tdc_clr, tdc_en, avg_valid, busy SHALL be registered/state-decoded, glitch-free.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE; tdc_clr, tdc_en, avg_valid, busy, timeout_err = 0; avg_out = 0; accumulator, counters = 0.
REQ-030 Reset asserted mid-burst SHALL abort with no timeout_err and no avg_valid; first start after release behaves as from power-up.

Verification
REQ-031 Reset: assert reset_n=0 at arbitrary point incl. WAIT -> all outputs 0 same cycle, FSM IDLE after release.
REQ-032 Single sample: avg_log2=0, start, tdc_done 3 cycles after tdc_en with phase_error=42 -> avg_out=42, avg_valid held until avg_ready, then busy=0 next cycle.
REQ-033 Averaging: avg_log2=2, samples 8, 9, 10, 12 -> exactly 4 tdc_clr pulses, avg_out=9 (39>>2).
REQ-034 Saturation width: avg_log2=3, eight samples of 1023 -> avg_out=1023.
REQ-035 Timeout: TIMEOUT=16, no tdc_done -> tdc_en high 16 cycles, single-cycle timeout_err, avg_valid never set, IDLE after; tdc_done on 16th cycle instead -> accepted, no timeout_err.
REQ-036 Protocol: start pulses during busy and tdc_done outside WAIT -> ignored; avg_ready held low 20 cycles in OUT -> avg_out and avg_valid stable throughout.

Source files
------------

// File: rtl/tdc_sequencer.sv
// tdc_sequencer: runs a burst of TDC clear/measure cycles and averages the phase-error samples.
// Handles per-sample timeouts and a valid/ready handshake for the result.
module tdc_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic       ref_clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] avg_log2,
    output logic       tdc_clr,
    output logic       tdc_en,
    input  logic       tdc_done,
    input  logic [9:0] phase_error,
    output logic [9:0] avg_out,
    output logic       avg_valid,
    input  logic       avg_ready,
    output logic       busy,
    output logic       timeout_err
);
    typedef enum logic [1:0] {IDLE, CLR, WAIT, OUT} state_t;
    state_t      state, state_nx;
    logic [1:0]  n_log;
    logic [12:0] acc;
    logic [2:0]  cnt;
    logic [7:0]  timer;
    logic [12:0] sum;
    logic        last, expire;

    assign sum       = acc + {3'b0, phase_error};
    assign last      = cnt == 3'((4'd1 << n_log) - 4'd1);
    assign expire    = timer == 8'(TIMEOUT - 1);
    assign tdc_clr   = state == CLR;
    assign tdc_en    = state == WAIT;
    assign avg_valid = state == OUT;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CLR;
            CLR:     state_nx = WAIT;
            WAIT:    if (tdc_done) state_nx = last ? OUT : CLR;
                     else if (expire) state_nx = IDLE;
            OUT:     if (avg_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            n_log       <= '0;
            acc         <= '0;
            cnt         <= '0;
            timer       <= '0;
            avg_out     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            // tdc_done takes priority over an expiring timer
            timeout_err <= state == WAIT && !tdc_done && expire;
            case (state)
                IDLE: if (start) begin
                    n_log <= avg_log2;
                    acc   <= '0;
                    cnt   <= '0;
                end
                CLR: timer <= '0;
                WAIT: if (tdc_done) begin
                    acc <= sum;
                    if (last) avg_out <= 10'(sum >> n_log);
                    else cnt <= cnt + 3'd1;
                end else if (expire) acc <= '0;
                else timer <= timer + 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tdc_sequencer.sv
// tb_tdc_sequencer: directed and randomized checks of tdc_sequencer against a burst-level model.
// A responder process plays the TDC, answering tdc_en after a programmable delay.
module tb_tdc_sequencer;
    localparam int TIMEOUT = 16;

    logic       ref_clk = 0, reset_n = 0, start = 0, tdc_done = 0, avg_ready = 0;
    logic [1:0] avg_log2 = 0;
    logic [9:0] phase_error = 0;
    logic       tdc_clr, tdc_en, avg_valid, busy, timeout_err;
    logic [9:0] avg_out;

    int checks = 0, errors = 0;

    tdc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .ref_clk(ref_clk), .reset_n(reset_n), .start(start), .avg_log2(avg_log2),
        .tdc_clr(tdc_clr), .tdc_en(tdc_en), .tdc_done(tdc_done), .phase_error(phase_error),
        .avg_out(avg_out), .avg_valid(avg_valid), .avg_ready(avg_ready), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 ref_clk = ~ref_clk;

    // Burst-level model: which phase the burst is in, the samples collected so far
    int         m_mode = 0;
    int         m_n = 1, m_wait = 0, m_sum = 0;
    int         m_got[$];
    logic [9:0] m_avg = 0;
    logic       m_terr = 0;

    always @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_avg = 0; m_terr = 0; m_got.delete();
        end else begin
            m_terr = 0;
            if (m_mode == 0) begin
                if (start) begin m_n = 1 << avg_log2; m_got.delete(); m_mode = 1; end
            end else if (m_mode == 1) begin
                m_mode = 2; m_wait = 0;
            end else if (m_mode == 2) begin
                if (tdc_done) begin
                    m_got.push_back(int'(phase_error));
                    if (m_got.size() == m_n) begin
                        m_sum = 0;
                        foreach (m_got[i]) m_sum += m_got[i];
                        m_avg = 10'(m_sum / m_n);
                        m_mode = 3;
                    end else m_mode = 1;
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin m_mode = 0; m_terr = 1; end
                end
            end else if (avg_ready) m_mode = 0;
        end
    end

    // TDC responder: answers on the (delay+1)-th tdc_en cycle
    int         r_fixed = 3, r_max = 5, r_cur = 3, r_cnt = 0, r_k = 0;
    bit         rand_delay = 0, noise = 0, r_use = 1;
    logic [9:0] r_vals[8];

    always @(negedge ref_clk) begin
        if (!busy) r_k = 0;
        else if (tdc_clr) r_k++;
        if (tdc_en) begin
            r_cnt++;
            tdc_done = r_cnt == r_cur + 1;
            phase_error = (tdc_done && r_use) ? r_vals[(r_k - 1) & 7] : 10'($urandom);
        end else begin
            r_cnt = 0;
            r_cur = rand_delay ? int'($urandom_range(0, r_max)) : r_fixed;
            tdc_done = noise && ($urandom_range(0, 3) == 0);
            phase_error = 10'($urandom);
        end
    end

    int clr_cnt = 0, en_cnt = 0, terr_cnt = 0, val_cnt = 0;
    always @(negedge ref_clk) begin
        if (tdc_clr) clr_cnt++;
        if (tdc_en) en_cnt++;
        if (timeout_err) terr_cnt++;
        if (avg_valid) val_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("tdc_clr", 32'(tdc_clr), 32'(m_mode == 1));
        chk("tdc_en", 32'(tdc_en), 32'(m_mode == 2));
        chk("avg_valid", 32'(avg_valid), 32'(m_mode == 3));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("avg_out", 32'(avg_out), 32'(m_avg));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic go(input logic [1:0] l);
        @(negedge ref_clk) begin avg_log2 = l; start = 1; end
        @(negedge ref_clk) begin start = 0; avg_log2 = 2'($urandom); end
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && !avg_valid; i++) @(negedge ref_clk);
        chk("valid_wait", 32'(avg_valid), 1);
    endtask

    task automatic release_out();
        @(negedge ref_clk) avg_ready = 1;
        @(negedge ref_clk) avg_ready = 0;
        chk("release_busy", 32'(busy), 0);
    endtask

    int c0, e0, t0, v0;
    logic [9:0] held;

    initial begin
        fork
            forever begin @(negedge ref_clk); compare(); end
        join_none
        repeat (3) @(negedge ref_clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_avg_out", 32'(avg_out), 0);
        reset_n = 1;

        // single sample, answered 3 cycles into tdc_en
        r_vals[0] = 42; r_fixed = 3;
        @(negedge ref_clk) begin avg_log2 = 0; start = 1; end
        @(negedge ref_clk) begin start = 0; avg_log2 = 3; end
        chk("lat_clr", 32'(tdc_clr), 1);
        chk("lat_en_low", 32'(tdc_en), 0);
        @(negedge ref_clk);
        chk("lat_en", 32'(tdc_en), 1);
        wait_valid(50);
        repeat (5) @(negedge ref_clk);
        chk("single_avg", 32'(avg_out), 42);
        chk("single_model", 32'(m_avg), 42);
        chk("single_valid", 32'(avg_valid), 1);
        release_out();

        // averaging of four samples
        r_vals[0] = 8; r_vals[1] = 9; r_vals[2] = 10; r_vals[3] = 12;
        rand_delay = 1; r_max = 5;
        c0 = clr_cnt;
        go(2);
        wait_valid(100);
        chk("avg4_clr_pulses", 32'(clr_cnt - c0), 4);
        chk("avg4_out", 32'(avg_out), 9);
        release_out();

        // full-scale eight samples
        foreach (r_vals[i]) r_vals[i] = 10'd1023;
        go(3);
        wait_valid(200);
        chk("sat_out", 32'(avg_out), 1023);
        release_out();

        // timeout with no tdc_done
        rand_delay = 0; r_fixed = 1000;
        e0 = en_cnt; t0 = terr_cnt; v0 = val_cnt;
        go(0);
        repeat (25) @(negedge ref_clk);
        chk("to_en_cycles", 32'(en_cnt - e0), 16);
        chk("to_err_pulses", 32'(terr_cnt - t0), 1);
        chk("to_no_valid", 32'(val_cnt - v0), 0);
        chk("to_idle", 32'(busy), 0);
        chk("to_avg_kept", 32'(avg_out), 1023);

        // tdc_done on the last allowed cycle
        r_fixed = 15; r_vals[0] = 77;
        e0 = en_cnt; t0 = terr_cnt;
        go(0);
        wait_valid(40);
        chk("late_no_err", 32'(terr_cnt - t0), 0);
        chk("late_en_cycles", 32'(en_cnt - e0), 16);
        chk("late_avg", 32'(avg_out), 77);
        release_out();

        // protocol: stray starts/tdc_done, long hold in OUT, start during handshake
        noise = 1; r_fixed = 4; r_vals[0] = 100; r_vals[1] = 201;
        go(1);
        repeat (8) @(negedge ref_clk) start = 1'($urandom);
        start = 0;
        wait_valid(60);
        held = avg_out;
        chk("proto_avg", 32'(avg_out), 150);
        repeat (20) begin
            @(negedge ref_clk) start = 1'($urandom);
            chk("hold_avg", 32'(avg_out), 32'(held));
            chk("hold_valid", 32'(avg_valid), 1);
        end
        @(negedge ref_clk) begin start = 1; avg_ready = 1; end
        @(negedge ref_clk) begin start = 0; avg_ready = 0; end
        chk("hs_start_ignored", 32'(busy), 0);

        // reset asserted in the middle of WAIT
        noise = 0; r_fixed = 6;
        go(2);
        repeat (4) @(negedge ref_clk);
        chk("mid_in_wait", 32'(tdc_en), 1);
        @(posedge ref_clk) #2 reset_n = 0;
        #1;
        chk("mrst_clr", 32'(tdc_clr), 0);
        chk("mrst_en", 32'(tdc_en), 0);
        chk("mrst_valid", 32'(avg_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_terr", 32'(timeout_err), 0);
        chk("mrst_avg", 32'(avg_out), 0);
        @(negedge ref_clk) reset_n = 1;
        @(negedge ref_clk);
        chk("mrst_idle", 32'(busy), 0);
        r_vals[0] = 5; r_fixed = 1;
        go(0);
        wait_valid(30);
        chk("post_rst_avg", 32'(avg_out), 5);
        release_out();

        // randomized traffic with occasional timeouts and resets
        rand_delay = 1; r_max = 18; r_use = 0; noise = 1;
        repeat (4000) begin
            @(negedge ref_clk);
            start = $urandom_range(0, 3) == 0;
            avg_log2 = 2'($urandom);
            avg_ready = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 399) == 0) begin
                #1 reset_n = 0;
                @(negedge ref_clk);
                #1 reset_n = 1;
            end
        end
        @(negedge ref_clk) begin start = 0; avg_ready = 1; end
        repeat (5) @(negedge ref_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
